// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;
  localparam int INSTR_W = 32;
  localparam logic [INSTR_W-1:0] HALT_WORD = 32'h0000_0000;

  typedef enum logic [1:0] {S_LOAD, S_FETCH, S_HALT} state_e;
endpackage

// File: rtl/instr_fetch_if.sv
// Instruction-memory port, IF/ID handshake and redirect bundle for instr_fetch.
// Loader stream signals exist only when IF_LOADER_EN is defined.
interface instr_fetch_if;
  import fetch_pkg::*;

  logic [31:0]        imem_adr;
  logic               imem_load;
  logic [INSTR_W-1:0] imem_in;
  logic [INSTR_W-1:0] imem_out;
  logic               redirect_valid;
  logic [31:0]        redirect_pc;
  logic               id_valid;
  logic               id_ready;
  logic [INSTR_W-1:0] id_instr;
  logic [31:0]        id_pc;
  logic               halt;
`ifdef IF_LOADER_EN
  logic               ld_valid;
  logic [INSTR_W-1:0] ld_data;
  logic               ld_last;
  logic               ld_ready;
`endif

  modport master (
    output imem_adr, imem_load, imem_in,
    input  imem_out,
    input  redirect_valid, redirect_pc,
    output id_valid, id_instr, id_pc, halt,
`ifdef IF_LOADER_EN
    input  ld_valid, ld_data, ld_last,
    output ld_ready,
`endif
    input  id_ready
  );

  modport slave (
    input  imem_adr, imem_load, imem_in,
    output imem_out,
    output redirect_valid, redirect_pc,
    input  id_valid, id_instr, id_pc, halt,
`ifdef IF_LOADER_EN
    output ld_valid, ld_data, ld_last,
    input  ld_ready,
`endif
    output id_ready
  );
endinterface

// File: rtl/fetch_loader.sv
// Boot loader: streams words into instruction memory at consecutive addresses
// while the fetch stage sits in LOAD; only instantiated with IF_LOADER_EN.
module fetch_loader
  import fetch_pkg::*;
#(
  parameter int MEM_SIZE = 1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               active,
  input  logic               ld_valid,
  input  logic               ld_last,
  input  logic [INSTR_W-1:0] ld_data,
  output logic               ld_ready,
  output logic               wr_en,
  output logic [31:0]        wr_adr,
  output logic [INSTR_W-1:0] wr_data,
  output logic               done
);
  localparam int CNT_W = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept;

  // The last slot of memory ends the load even without ld_last.
  always_comb begin
    accept = active && ld_valid;
    done   = accept && (ld_last || (cnt_q == CNT_W'(MEM_SIZE - 1)));
    cnt_d  = cnt_q;
    if (accept) cnt_d = done ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign ld_ready = active;
  assign wr_en    = accept;
  assign wr_adr   = 32'(cnt_q);
  assign wr_data  = active ? ld_data : '0;
endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, reads instruction memory and fills the IF/ID slot.
// Optional boot loader enabled by defining IF_LOADER_EN.
module instr_fetch
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          MEM_SIZE = 1024
) (
  input  logic          clk,
  input  logic          rst,
  instr_fetch_if.master bus
);
  localparam logic [31:0] ADR_MASK = 32'(MEM_SIZE - 1);

  state_e             state_q, state_d;
  logic [31:0]        pc_q, pc_d;
  logic               id_valid_q, id_valid_d;
  logic [INSTR_W-1:0] id_instr_q, id_instr_d;
  logic [31:0]        id_pc_q, id_pc_d;
  logic               halt_q, halt_d;
  logic [31:0]        fetch_adr;

  assign fetch_adr = (pc_q >> 2) & ADR_MASK;

`ifdef IF_LOADER_EN
  localparam state_e RESET_STATE = S_LOAD;
  logic               ld_wr_en;
  logic [31:0]        ld_wr_adr;
  logic [INSTR_W-1:0] ld_wr_data;
  logic               ld_done;

  fetch_loader #(.MEM_SIZE(MEM_SIZE)) u_loader (
    .clk      (clk),
    .rst      (rst),
    .active   (state_q == S_LOAD),
    .ld_valid (bus.ld_valid),
    .ld_last  (bus.ld_last),
    .ld_data  (bus.ld_data),
    .ld_ready (bus.ld_ready),
    .wr_en    (ld_wr_en),
    .wr_adr   (ld_wr_adr),
    .wr_data  (ld_wr_data),
    .done     (ld_done)
  );

  assign bus.imem_adr  = (state_q == S_LOAD) ? ld_wr_adr : fetch_adr;
  assign bus.imem_load = ld_wr_en;
  assign bus.imem_in   = ld_wr_data;
`else
  localparam state_e RESET_STATE = S_FETCH;

  assign bus.imem_adr  = fetch_adr;
  assign bus.imem_load = 1'b0;
  assign bus.imem_in   = '0;
`endif

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    id_valid_d = id_valid_q;
    id_instr_d = id_instr_q;
    id_pc_d    = id_pc_q;
    halt_d     = halt_q;
    case (state_q)
`ifdef IF_LOADER_EN
      S_LOAD: begin
        if (ld_done) begin
          state_d = S_FETCH;
          pc_d    = RESET_PC;
        end
      end
`endif
      S_FETCH: begin
        // A redirect squashes whatever would have been captured this cycle.
        if (bus.redirect_valid) begin
          pc_d       = bus.redirect_pc & ~32'h3;
          id_valid_d = 1'b0;
          halt_d     = 1'b0;
        end else if (!id_valid_q || bus.id_ready) begin
          if (bus.imem_out != HALT_WORD) begin
            id_instr_d = bus.imem_out;
            id_pc_d    = pc_q;
            id_valid_d = 1'b1;
            pc_d       = pc_q + 32'd4;
          end else begin
            id_valid_d = 1'b0;
            halt_d     = 1'b1;
            state_d    = S_HALT;
          end
        end
      end
      S_HALT: begin
        if (bus.redirect_valid) begin
          pc_d       = bus.redirect_pc & ~32'h3;
          id_valid_d = 1'b0;
          halt_d     = 1'b0;
          state_d    = S_FETCH;
        end else begin
          id_valid_d = 1'b0;
          halt_d     = 1'b1;
        end
      end
      default: state_d = RESET_STATE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RESET_STATE;
      pc_q       <= RESET_PC;
      id_valid_q <= 1'b0;
      id_instr_q <= '0;
      id_pc_q    <= '0;
      halt_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      id_valid_q <= id_valid_d;
      id_instr_q <= id_instr_d;
      id_pc_q    <= id_pc_d;
      halt_q     <= halt_d;
    end
  end

  assign bus.id_valid = id_valid_q;
  assign bus.id_instr = id_instr_q;
  assign bus.id_pc    = id_pc_q;
  assign bus.halt     = halt_q;
endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage of the RISC-V core, sitting directly upstream of the instruction memory and downstream-feeding the decode stage. Owns the program counter, drives the word address into the instruction memory, captures the returned word into a registered IF/ID slot with a valid/ready handshake toward decode, and accepts branch/jump redirects. An optional boot loader writes the program image into instruction memory through its load port before fetching starts.

## Interface
- RESET_PC, 32'h0000_0000 — byte address of first fetch after reset or load completion
- MEM_SIZE, 1024 — instruction memory depth in 32-bit words; power of two
- clk  in  1  — single clock, all state updates on rising edge
- rst  in  1  — reset, synchronous, active-high
- imem_adr  out  32  — word index into instruction memory
- imem_load  out  1  — instruction memory write enable
- imem_in  out  32  — instruction memory write data
- imem_out  in  32  — instruction word read combinationally at imem_adr
- redirect_valid  in  1  — redirect request from execute
- redirect_pc  in  32  — redirect target byte address
- id_valid  out  1  — IF/ID slot holds an instruction
- id_ready  in  1  — decode accepts the slot this cycle
- id_instr  out  32  — fetched instruction
- id_pc  out  32  — byte address of id_instr
- halt  out  1  — fetch stopped on all-zero word
- ld_valid / ld_data[31:0] / ld_last  in — loader stream (only with IF_LOADER_EN)
- ld_ready  out  1 — loader accepts a word (only with IF_LOADER_EN)

## Operation
- States: LOAD (macro only), FETCH, HALT.
- imem_adr = (pc >> 2) & (MEM_SIZE-1) in FETCH/HALT; wraps modulo MEM_SIZE. pc[1:0] always 0; redirect_pc[1:0] ignored.
- FETCH, slot free (!id_valid or id_ready): if imem_out != 0 → id_instr<=imem_out, id_pc<=pc, id_valid<=1, pc<=pc+4 (32-bit wrap). If imem_out == 0 → id_valid<=0, halt<=1, state HALT, pc held.
- FETCH, slot stalled (id_valid and !id_ready): pc, id_* held unchanged.
- redirect_valid (FETCH or HALT): highest priority; pc<=redirect_pc & ~3, id_valid<=0, halt<=0, state FETCH; no capture that cycle, regardless of id_ready.
- HALT: id_valid 0, halt 1, held until redirect or rst.
- imem_load 0 and imem_in 0 outside LOAD.

## Timing
- Reset values: pc=RESET_PC, id_valid=0, id_instr=0, id_pc=0, halt=0, state LOAD if IF_LOADER_EN else FETCH; ld word counter 0.
- rst mid-operation (including mid-load): all of the above restored next edge; partial load abandoned.
- Latency: word at pc appears on id_* one cycle after pc drives imem_adr; first id_valid one cycle after rst deasserts (no loader).
- Throughput: one instruction per cycle while id_ready=1.
- Redirect at edge N: id_valid=0 after N; target instruction valid after N+1.
- Handshake: transfer when id_valid && id_ready; id_* stable while id_valid && !id_ready.

## Configuration
- IF_LOADER_EN defined: reset enters LOAD; ld_ready=1, imem_load=ld_valid, imem_adr=counter, imem_in=ld_data; counter increments per accepted word; ld_last accepted or counter reaching MEM_SIZE-1 → FETCH with pc=RESET_PC next cycle. redirect_valid ignored in LOAD.
- Undefined: no LOAD state, no ld_* ports, imem_load/imem_in tied 0.

## Structure
- Shared package fetch_pkg: state enum (S_LOAD, S_FETCH, S_HALT), HALT_WORD = 32'h0, INSTR_W = 32.
- One sub-module natural: fetch_loader (counter and ld_* handshake), instantiated only under IF_LOADER_EN.

## Test plan
- Reset, memory words 0..3 = 0x00500093, 0x00108113, 0x002081B3, 0x0 with id_ready=1 → id_pc 0,4,8 on consecutive cycles, then halt=1, id_valid=0.
- id_ready=0 for 3 cycles while id_valid=1 at pc 4 → id_instr 0x00108113 and imem_adr 2 held; resumes at pc 8.
- redirect_valid with redirect_pc=0x0000_0013 while stalled → next cycle id_valid=0; following cycle id_pc=0x10.
- pc=0x0000_0FFC, MEM_SIZE=1024 → next imem_adr 0 (wrap), id_pc=0x1000.
- IF_LOADER_EN: stream 3 words with ld_last on third, then rst asserted mid second load run → words at 0..2 written, FETCH from RESET_PC; rst returns to LOAD with counter 0.
- HALT then redirect_pc=0x8 → halt=0, instruction at word 2 valid two cycles later.
